// File: rtl/ex_muldiv_if.sv
// Handshake/bus bundle between the ID/EX pipeline and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  valid_i;
    logic [2:0]            op_i;
    logic [XLEN-1:0]       a_i;
    logic [XLEN-1:0]       b_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  flush_i;
    logic                  stall_o;
    logic                  valid_o;
    logic [XLEN-1:0]       result_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;

    // Pipeline side: issues ops, observes stall and write-back.
    modport master (
        output valid_i, op_i, a_i, b_i, wd_i, wreg_i, flush_i,
        input  stall_o, valid_o, result_o, wd_o, wreg_o
    );

    // Execute unit side.
    modport slave (
        input  valid_i, op_i, a_i, b_i, wd_i, wreg_i, flush_i,
        output stall_o, valid_o, result_o, wd_o, wreg_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide over
// operand magnitudes, BPC bits per cycle, with a final sign-correction cycle.
//
// state | meaning
// IDLE  | waiting for an op; divide-by-zero and signed overflow finish here
// CALC  | iterating, BPC bits per cycle, N = XLEN/BPC cycles
// SIGN  | sign correction and result selection
// DONE  | result presented for one cycle
//
// BPC must be a power of two in 1..8 that divides XLEN.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int BPC        = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    // Multiply: {high product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]     acc_q, acc_d;
    // Multiplicand or divisor magnitude.
    logic [XLEN-1:0]       opb_q, opb_d;
    logic                  neg_q, neg_d;
    logic                  aneg_q, aneg_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic                  is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic                  div_zero, div_ovf, fast;
    logic [XLEN-1:0]       fast_res;
    logic [2*XLEN-1:0]     step;
    logic [XLEN:0]         part, diff;
    logic [2*XLEN-1:0]     prod;
    logic [XLEN-1:0]       quo, rem, sign_res;

    // Operand decode: signedness, magnitudes and the two divide special cases.
    always_comb begin
        is_div   = bus.op_i[2];
        a_sgn    = is_div ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
        b_sgn    = is_div ? ~bus.op_i[0] : ~bus.op_i[1];
        a_neg    = a_sgn & bus.a_i[XLEN-1];
        b_neg    = b_sgn & bus.b_i[XLEN-1];
        a_mag    = a_neg ? -bus.a_i : bus.a_i;
        b_mag    = b_neg ? -bus.b_i : bus.b_i;
        div_zero = is_div & (bus.b_i == '0);
        div_ovf  = is_div & ~bus.op_i[0] & (bus.a_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.b_i == '1);
        fast     = div_zero | div_ovf;
        if (div_zero) fast_res = bus.op_i[1] ? bus.a_i : '1;
        else          fast_res = bus.op_i[1] ? '0 : bus.a_i;
    end

    // One CALC cycle: BPC shift-add or restoring-subtract steps.
    always_comb begin
        step = acc_q;
        part = '0;
        diff = '0;
        for (int i = 0; i < BPC; i++) begin
            if (op_q[2]) begin
                part = step[2*XLEN-1:XLEN-1];
                diff = part - {1'b0, opb_q};
                if (!diff[XLEN]) step = {diff[XLEN-1:0], step[XLEN-2:0], 1'b1};
                else             step = {part[XLEN-1:0], step[XLEN-2:0], 1'b0};
            end else begin
                part = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, opb_q} : '0);
                step = {part, step[XLEN-1:1]};
            end
        end
    end

    // Sign correction and selection of the architectural result.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            if (op_q[1]) sign_res = aneg_q ? -rem : rem;
            else         sign_res = neg_q ? -quo : quo;
        end else begin
            sign_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            aneg_q   <= aneg_d;
            result_q <= result_d;
        end
    end

    // Next state; a flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.valid_i) state_d = fast ? DONE : CALC;
                CALC: if (cnt_q == CW'(N - 1)) state_d = SIGN;
                SIGN: state_d = DONE;
                // valid_i may still be high here for the finished instruction.
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath register updates and handshake outputs.
    always_comb begin
        op_d     = op_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        aneg_d   = aneg_q;
        result_d = result_q;
        if (!bus.flush_i) begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i) begin
                        op_d   = bus.op_i;
                        wd_d   = bus.wd_i;
                        wreg_d = bus.wreg_i;
                        cnt_d  = '0;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                        opb_d  = b_mag;
                        neg_d  = a_neg ^ b_neg;
                        aneg_d = a_neg;
                        if (fast) result_d = fast_res;
                    end
                end
                CALC: begin
                    acc_d = step;
                    cnt_d = cnt_q + CW'(1);
                end
                SIGN: result_d = sign_res;
                default: ;
            endcase
        end
        bus.stall_o  = rst & ~bus.flush_i &
                       (((state_q == IDLE) & bus.valid_i) | (state_q == CALC) | (state_q == SIGN));
        bus.valid_o  = (state_q == DONE) & ~bus.flush_i;
        bus.result_o = result_q;
        bus.wd_o     = wd_q;
        bus.wreg_o   = wreg_q;
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: one BPC=1 instance and one BPC=4 instance
// sharing operand inputs, each with its own valid_i.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid1 = 1'b0;
    logic        valid4 = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  wd = '0;
    logic        wreg = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  wd_next = 5'd1;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) mif1 ();
    ex_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) mif4 ();

    assign mif1.valid_i = valid1;
    assign mif1.op_i    = op;
    assign mif1.a_i     = a;
    assign mif1.b_i     = b;
    assign mif1.wd_i    = wd;
    assign mif1.wreg_i  = wreg;
    assign mif1.flush_i = flush;
    assign mif4.valid_i = valid4;
    assign mif4.op_i    = op;
    assign mif4.a_i     = a;
    assign mif4.b_i     = b;
    assign mif4.wd_i    = wd;
    assign mif4.wreg_i  = wreg;
    assign mif4.flush_i = flush;

    ex_muldiv #(.XLEN(32), .BPC(1), .REG_ADDR_W(5)) dut1 (
        .clk(clk), .rst(rst_n), .bus(mif1.slave));
    ex_muldiv #(.XLEN(32), .BPC(4), .REG_ADDR_W(5)) dut4 (
        .clk(clk), .rst(rst_n), .bus(mif4.slave));

    // Issue one op at posedge+1 and check stall/valid every cycle up to the
    // expected DONE cycle; returns at posedge+1 of the cycle after DONE.
    task automatic run_op(input bit use4, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expv, input int lat,
                          input string name);
        logic        v, s, wr;
        logic [31:0] r;
        logic [4:0]  w;
        logic [4:0]  exp_wd;
        logic        exp_wreg;
        op = o; a = x; b = y;
        wd = wd_next; wreg = wd_next[0];
        exp_wd = wd_next; exp_wreg = wd_next[0];
        wd_next = wd_next + 5'd3;
        if (use4) valid4 = 1'b1; else valid1 = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            v  = use4 ? mif4.valid_o  : mif1.valid_o;
            s  = use4 ? mif4.stall_o  : mif1.stall_o;
            r  = use4 ? mif4.result_o : mif1.result_o;
            w  = use4 ? mif4.wd_o     : mif1.wd_o;
            wr = use4 ? mif4.wreg_o   : mif1.wreg_o;
            tests++;
            if (s !== (c < lat)) begin
                fails++;
                $display("FAIL %s stall cycle %0d: got %b want %b", name, c, s, (c < lat));
            end
            tests++;
            if (v !== (c == lat)) begin
                fails++;
                $display("FAIL %s valid_o cycle %0d: got %b want %b", name, c, v, (c == lat));
            end
            if (c == lat) begin
                tests++;
                if (r !== expv) begin
                    fails++;
                    $display("FAIL %s result: got %h want %h", name, r, expv);
                end
                tests++;
                if (w !== exp_wd || wr !== exp_wreg) begin
                    fails++;
                    $display("FAIL %s wd/wreg: got %0d/%b want %0d/%b", name, w, wr, exp_wd, exp_wreg);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        // valid_i is still high across the DONE edge: the unit must not restart.
        @(posedge clk); #1;
        valid1 = 1'b0; valid4 = 1'b0;
        #1;
        s = use4 ? mif4.stall_o : mif1.stall_o;
        v = use4 ? mif4.valid_o : mif1.valid_o;
        tests++;
        if (s !== 1'b0 || v !== 1'b0) begin
            fails++;
            $display("FAIL %s idle after done: stall %b valid %b want 0 0", name, s, v);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (mif1.stall_o !== 1'b0 || mif1.valid_o !== 1'b0 || mif1.wreg_o !== 1'b0) begin
            fails++;
            $display("FAIL reset flags: stall %b valid %b wreg %b want 0", mif1.stall_o, mif1.valid_o, mif1.wreg_o);
        end
        tests++;
        if (mif1.result_o !== 32'h0 || mif1.wd_o !== 5'h0) begin
            fails++;
            $display("FAIL reset data: result %h wd %0d want 0", mif1.result_o, mif1.wd_o);
        end
        tests++;
        if (mif4.stall_o !== 1'b0 || mif4.valid_o !== 1'b0 || mif4.result_o !== 32'h0) begin
            fails++;
            $display("FAIL reset bpc4: stall %b valid %b result %h want 0", mif4.stall_o, mif4.valid_o, mif4.result_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op(1'b0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul");
        run_op(1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh");
        run_op(1'b0, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulhu");
        run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "mulhsu");
    endtask

    task automatic test_div();
        run_op(1'b0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div");
        run_op(1'b0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem");
        run_op(1'b0, 3'b101, 32'd100,      32'd7, 32'd14,       34, "divu");
        run_op(1'b0, 3'b111, 32'd100,      32'd7, 32'd2,        34, "remu");
        run_op(1'b0, 3'b100, 32'h80000000, 32'd3, 32'hD5555556, 34, "div_min");
        run_op(1'b0, 3'b110, 32'h80000000, 32'd3, 32'hFFFFFFFE, 34, "rem_min");
    endtask

    task automatic test_fast_path();
        run_op(1'b0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, "divu_by_zero");
        run_op(1'b0, 3'b110, 32'd5,        32'd0,        32'd5,        1, "rem_by_zero");
        run_op(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow");
        run_op(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1, "rem_overflow");
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, "b2b_mul");
        run_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "b2b_mulhu");
        run_op(1'b0, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "b2b_div_zero");
    endtask

    task automatic test_flush();
        bit bad;
        op = 3'b100; a = 32'd100; b = 32'd7; wd = 5'd9; wreg = 1'b1;
        valid1 = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mif1.stall_o !== 1'b1 || mif1.valid_o !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL flush pre: stall/valid wrong in cycles 0..9");
        end
        flush = 1'b1;
        @(negedge clk);
        tests++;
        if (mif1.stall_o !== 1'b0 || mif1.valid_o !== 1'b0) begin
            fails++;
            $display("FAIL flush cycle: stall %b valid %b want 0 0", mif1.stall_o, mif1.valid_o);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        run_op(1'b0, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_after_flush");
    endtask

    task automatic test_reset_mid();
        bit bad;
        op = 3'b000; a = 32'd3; b = 32'd5; wd = 5'd17; wreg = 1'b1;
        valid1 = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        valid1 = 1'b0;
        #1;
        tests++;
        if (mif1.stall_o !== 1'b0 || mif1.valid_o !== 1'b0 || mif1.wreg_o !== 1'b0) begin
            fails++;
            $display("FAIL mid reset flags: stall %b valid %b wreg %b want 0", mif1.stall_o, mif1.valid_o, mif1.wreg_o);
        end
        tests++;
        if (mif1.result_o !== 32'h0 || mif1.wd_o !== 5'h0) begin
            fails++;
            $display("FAIL mid reset data: result %h wd %0d want 0", mif1.result_o, mif1.wd_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mif1.valid_o !== 1'b0 || mif1.stall_o !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL mid reset: activity after release");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bpc4();
        run_op(1'b1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 10, "bpc4_mul");
        run_op(1'b1, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 10, "bpc4_div");
        run_op(1'b1, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 10, "bpc4_mulh");
        run_op(1'b1, 3'b111, 32'd100,      32'd7,        32'd2,        10, "bpc4_remu");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_bpc4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
